// File: rtl/idli_sqi_resp.sv
// idli_sqi_resp: SQI serial-RAM responder that decodes sequential READ/WRITE into a byte-memory port.
// Define IDLI_SQI_RESP_CMD_CHECK_EN to send any command other than 0x02/0x03 to IGNORE.

module idli_sqi_resp #(
  parameter int ADDR_W        = 16,
  parameter int DUMMY_NIBBLES = 2
) (
  input  logic              i_resp_gck,
  input  logic              i_resp_rst_n,
  input  logic              i_resp_sck,
  input  logic              i_resp_cs,
  input  logic [3:0]        i_resp_sio,
  output logic [3:0]        o_resp_sio,
  output logic              o_resp_sio_oe,
  output logic [ADDR_W-1:0] o_resp_mem_addr,
  output logic [7:0]        o_resp_mem_wdata,
  output logic              o_resp_mem_we,
  output logic              o_resp_mem_re,
  input  logic [7:0]        i_resp_mem_rdata
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DUMMY  = 3'd3;
  localparam logic [2:0] ST_RDATA  = 3'd4;
  localparam logic [2:0] ST_WDATA  = 3'd5;
`ifdef IDLI_SQI_RESP_CMD_CHECK_EN
  localparam logic [2:0] ST_IGNORE = 3'd6;
`endif

  localparam logic [2:0]        DUMMY_LAST = 3'(DUMMY_NIBBLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = 1;

  logic [2:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [3:0]        shift_q, shift_d;
  logic              is_read_q, is_read_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        buf_q, buf_d;
  logic              load_q, load_d;
  logic              hi_next_q, hi_next_d;
  logic              lo_sent_q, lo_sent_d;
  logic              sck_q, sck_d;
  logic [3:0]        sio_q, sio_d;
  logic              oe_q, oe_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;

  logic              rise;
  logic              fall;
  logic [7:0]        cur_buf;
  logic [ADDR_W-1:0] addr_shift;
  logic [ADDR_W-1:0] addr_inc;
`ifdef IDLI_SQI_RESP_CMD_CHECK_EN
  logic [7:0]        cmd_byte;
`endif

  assign rise       = i_resp_sck & ~sck_q & ~i_resp_cs;
  assign fall       = ~i_resp_sck & sck_q & ~i_resp_cs;
  // A fall can land in the cycle the prefetched byte arrives, so bypass the buffer then.
  assign cur_buf    = load_q ? i_resp_mem_rdata : buf_q;
  assign addr_shift = {addr_q[ADDR_W-5:0], i_resp_sio};
  assign addr_inc   = addr_q + ADDR_ONE;
`ifdef IDLI_SQI_RESP_CMD_CHECK_EN
  assign cmd_byte   = {shift_q, i_resp_sio};
`endif

  assign o_resp_sio       = sio_q;
  assign o_resp_sio_oe    = oe_q;
  assign o_resp_mem_addr  = mem_addr_q;
  assign o_resp_mem_wdata = wdata_q;
  assign o_resp_mem_we    = we_q;
  assign o_resp_mem_re    = re_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    is_read_d  = is_read_q;
    addr_d     = addr_q;
    buf_d      = cur_buf;
    load_d     = re_q;
    hi_next_d  = hi_next_q;
    lo_sent_d  = lo_sent_q;
    sck_d      = i_resp_sck;
    sio_d      = sio_q;
    oe_d       = oe_q;
    mem_addr_d = mem_addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    re_d       = 1'b0;

    if (i_resp_cs) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_CMD;
          cnt_d   = 3'd0;
        end
        ST_CMD: if (rise) begin
          shift_d = i_resp_sio;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd1) begin
            cnt_d   = 3'd0;
            state_d = ST_ADDR;
`ifdef IDLI_SQI_RESP_CMD_CHECK_EN
            if (cmd_byte == 8'h03)      is_read_d = 1'b1;
            else if (cmd_byte == 8'h02) is_read_d = 1'b0;
            else                        state_d   = ST_IGNORE;
`else
            is_read_d = i_resp_sio[0];
`endif
          end
        end
        ST_ADDR: if (rise) begin
          addr_d = addr_shift;
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'd5) begin
            cnt_d = 3'd0;
            if (is_read_q) begin
              re_d       = 1'b1;
              mem_addr_d = addr_shift;
              hi_next_d  = 1'b1;
              lo_sent_d  = 1'b0;
              state_d    = (DUMMY_NIBBLES == 0) ? ST_RDATA : ST_DUMMY;
            end else begin
              state_d = ST_WDATA;
            end
          end
        end
        ST_DUMMY: if (rise) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == DUMMY_LAST) begin
            cnt_d   = 3'd0;
            state_d = ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (fall) begin
            oe_d = 1'b1;
            if (hi_next_q) begin
              sio_d     = cur_buf[7:4];
              hi_next_d = 1'b0;
            end else begin
              sio_d     = cur_buf[3:0];
              hi_next_d = 1'b1;
              lo_sent_d = 1'b1;
            end
          end
          // The initiator has taken the low nibble: prefetch the next byte.
          if (rise && lo_sent_q) begin
            lo_sent_d  = 1'b0;
            addr_d     = addr_inc;
            mem_addr_d = addr_inc;
            re_d       = 1'b1;
          end
        end
        ST_WDATA: if (rise) begin
          if (cnt_q == 3'd0) begin
            shift_d = i_resp_sio;
            cnt_d   = 3'd1;
          end else begin
            we_d       = 1'b1;
            wdata_d    = {shift_q, i_resp_sio};
            mem_addr_d = addr_q;
            addr_d     = addr_inc;
            cnt_d      = 3'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_resp_gck or negedge i_resp_rst_n) begin
    if (!i_resp_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= 4'd0;
      is_read_q  <= 1'b0;
      addr_q     <= '0;
      buf_q      <= 8'd0;
      load_q     <= 1'b0;
      hi_next_q  <= 1'b1;
      lo_sent_q  <= 1'b0;
      sck_q      <= 1'b0;
      sio_q      <= 4'd0;
      oe_q       <= 1'b0;
      mem_addr_q <= '0;
      wdata_q    <= 8'd0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      is_read_q  <= is_read_d;
      addr_q     <= addr_d;
      buf_q      <= buf_d;
      load_q     <= load_d;
      hi_next_q  <= hi_next_d;
      lo_sent_q  <= lo_sent_d;
      sck_q      <= sck_d;
      sio_q      <= sio_d;
      oe_q       <= oe_d;
      mem_addr_q <= mem_addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
    end
  end

endmodule

// File: tb/tb_idli_sqi_resp.sv
// Self-checking bench for idli_sqi_resp: an SQI initiator driver, a RAM behind the memory port,
// and a byte-array reference model of what each transaction must do to that RAM.

module tb_idli_sqi_resp;

   localparam int ADDR_W = 16;
   localparam int DUMMY  = 2;

   logic              clk = 1'b0;
   logic              rstN = 1'b0;
   logic              sck = 1'b0;
   logic              cs = 1'b1;
   logic [3:0]        sioIn = 4'd0;
   logic [3:0]        sioOut;
   logic              sioOe;
   logic [ADDR_W-1:0] memAddr;
   logic [7:0]        memWdata;
   logic              memWe;
   logic              memRe;
   logic [7:0]        memRdata = 8'd0;

   int checks = 0;
   int errors = 0;
   int bothCount = 0;

   logic [7:0]  dutMem [0:65535];
   logic [7:0]  refMem [0:65535];
   logic [23:0] weLog[$];
   logic [15:0] reLog[$];
   logic [3:0]  txQ[$];
   logic [3:0]  rxQ[$];
   logic        oeQ[$];
   logic [7:0]  wbQ[$];

   always #5 clk = ~clk;

   idli_sqi_resp #(.ADDR_W(ADDR_W), .DUMMY_NIBBLES(DUMMY)) dut (
      .i_resp_gck       (clk),
      .i_resp_rst_n     (rstN),
      .i_resp_sck       (sck),
      .i_resp_cs        (cs),
      .i_resp_sio       (sioIn),
      .o_resp_sio       (sioOut),
      .o_resp_sio_oe    (sioOe),
      .o_resp_mem_addr  (memAddr),
      .o_resp_mem_wdata (memWdata),
      .o_resp_mem_we    (memWe),
      .o_resp_mem_re    (memRe),
      .i_resp_mem_rdata (memRdata)
   );

   // RAM behind the memory port: read data appears the cycle after the strobe.
   always @(posedge clk) begin
      if (memWe) dutMem[memAddr] <= memWdata;
      if (memRe) memRdata <= dutMem[memAddr];
   end

   // Strobe recorder, sampled mid-cycle so every one-cycle pulse is seen exactly once.
   always @(negedge clk) begin
      if (memWe && memRe) bothCount++;
      if (memWe) weLog.push_back({memAddr, memWdata});
      if (memRe) reLog.push_back(memAddr);
   end

   // Hard stop in case the bench itself wedges.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One SCK period: low phase carrying tx, then the rise; rx/oe are what the initiator sees at the rise.
   task automatic clockNibble(input logic [3:0] tx, output logic [3:0] rx, output logic rxOe);
      sck = 1'b0;
      sioIn = tx;
      waitCycles($urandom_range(2, 3));
      rx = sioOut;
      rxOe = sioOe;
      sck = 1'b1;
      waitCycles($urandom_range(2, 3));
   endtask

   // Command, 24-bit address, then nTail nibbles taken from txQ (random when empty); tail rx/oe are logged.
   task automatic applyStimulus(input logic [7:0] cmd, input logic [23:0] addr, input int nTail, input logic endCs);
      logic [3:0] rx;
      logic       oe;
      logic [3:0] tx;
      rxQ.delete();
      oeQ.delete();
      cs = 1'b0;
      waitCycles(2);
      clockNibble(cmd[7:4], rx, oe);
      clockNibble(cmd[3:0], rx, oe);
      for (int i = 5; i >= 0; i--) clockNibble(addr[i*4 +: 4], rx, oe);
      for (int i = 0; i < nTail; i++) begin
         tx = (txQ.size() != 0) ? txQ.pop_front() : 4'($urandom);
         clockNibble(tx, rx, oe);
         rxQ.push_back(rx);
         oeQ.push_back(oe);
      end
      if (endCs) begin
         cs = 1'b1;
         waitCycles(2);
         sck = 1'b0;
         waitCycles(3);
         checkOutput("oe after deselect", sioOe, 1'b0);
      end
   endtask

   task automatic doWrite(input logic [23:0] addr, input int n);
      logic [7:0]  b;
      logic [15:0] a;
      logic [23:0] expWe[$];
      weLog.delete();
      reLog.delete();
      txQ.delete();
      for (int i = 0; i < n; i++) begin
         b = (wbQ.size() != 0) ? wbQ.pop_front() : 8'($urandom);
         a = addr[15:0] + 16'(i);
         txQ.push_back(b[7:4]);
         txQ.push_back(b[3:0]);
         expWe.push_back({a, b});
         refMem[a] = b;
      end
      applyStimulus(8'h02, addr, 2 * n, 1'b1);
      checkOutput("we count", weLog.size(), n);
      for (int i = 0; i < n && i < weLog.size(); i++) checkOutput("we addr/data", weLog[i], expWe[i]);
      checkOutput("re during write", reLog.size(), 0);
   endtask

   // Read of n bytes: dummy nibbles undriven, data nibbles MSB-first, one prefetch strobe per byte plus the first.
   task automatic doRead(input logic [7:0] cmd, input logic [23:0] addr, input int n);
      logic [7:0]  b;
      logic [15:0] a;
      weLog.delete();
      reLog.delete();
      txQ.delete();
      applyStimulus(cmd, addr, DUMMY + 2 * n, 1'b1);
      for (int i = 0; i < DUMMY; i++) checkOutput("dummy oe", oeQ[i], 1'b0);
      for (int i = 0; i < 2 * n; i++) begin
         b = refMem[addr[15:0] + 16'(i / 2)];
         checkOutput("read oe", oeQ[DUMMY + i], 1'b1);
         checkOutput("read nibble", rxQ[DUMMY + i], (i % 2 == 0) ? b[7:4] : b[3:0]);
      end
      checkOutput("re count", reLog.size(), n + 1);
      for (int i = 0; i <= n && i < reLog.size(); i++) begin
         a = addr[15:0] + 16'(i);
         checkOutput("re addr", reLog[i], a);
      end
      checkOutput("we during read", weLog.size(), 0);
   endtask

   initial begin
      logic [23:0] rAddr;
      int          rLen;
      for (int i = 0; i < 65536; i++) begin
         dutMem[i] = 8'($urandom);
         refMem[i] = dutMem[i];
      end

      $display("[TB] reset state");
      waitCycles(3);
      checkOutput("reset sio", sioOut, 4'd0);
      checkOutput("reset oe", sioOe, 1'b0);
      checkOutput("reset addr", memAddr, 16'd0);
      checkOutput("reset wdata", memWdata, 8'd0);
      checkOutput("reset we", memWe, 1'b0);
      checkOutput("reset re", memRe, 1'b0);
      rstN = 1'b1;
      waitCycles(3);

      $display("[TB] directed write then read at 0x0010");
      wbQ = '{8'hA5, 8'h3C};
      doWrite(24'h000010, 2);
      doRead(8'h03, 24'h000010, 2);

      $display("[TB] write wrapping at 0xFFFF");
      wbQ = '{8'h11, 8'h22};
      doWrite(24'h00FFFF, 2);
      doRead(8'h03, 24'h00FFFF, 2);

      $display("[TB] deselect after one write nibble");
      weLog.delete();
      txQ = '{4'h7};
      applyStimulus(8'h02, 24'h000000, 1, 1'b1);
      checkOutput("partial byte we", weLog.size(), 0);
      doRead(8'h03, 24'h000000, 1);

      $display("[TB] command 0x05");
`ifdef IDLI_SQI_RESP_CMD_CHECK_EN
      weLog.delete();
      reLog.delete();
      applyStimulus(8'h05, 24'h000040, 6, 1'b1);
      checkOutput("ignored re", reLog.size(), 0);
      checkOutput("ignored we", weLog.size(), 0);
      for (int i = 0; i < 6; i++) checkOutput("ignored oe", oeQ[i], 1'b0);
`else
      doRead(8'h05, 24'h000040, 2);
`endif

      $display("[TB] async reset during read data");
      applyStimulus(8'h03, 24'h000010, DUMMY + 1, 1'b0);
      sck = 1'b0;
      waitCycles(3);
      checkOutput("oe before reset", sioOe, 1'b1);
      rstN = 1'b0;
      #1;
      checkOutput("reset oe async", sioOe, 1'b0);
      checkOutput("reset re async", memRe, 1'b0);
      checkOutput("reset we async", memWe, 1'b0);
      cs = 1'b1;
      waitCycles(3);
      rstN = 1'b1;
      waitCycles(3);
      doRead(8'h03, 24'h000010, 2);

      $display("[TB] randomized write/readback");
      for (int k = 0; k < 8; k++) begin
         rAddr = 24'($urandom);
         if (k == 2) rAddr = 24'hAB_FFFE;
         rLen = $urandom_range(1, 3);
         doWrite(rAddr, rLen);
         doRead(8'h03, rAddr, $urandom_range(1, 4));
      end

      checkOutput("re and we together", bothCount, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/idli_sqi_resp.md
Name: idli_sqi_resp

Overview:
- SQI serial-RAM responder: the memory-side end of the core's quad-SPI memory interface (SCK, CS, 4-bit SIO with direction control).
- Decodes sequential-mode READ (0x03) and WRITE (0x02) transactions into a simple synchronous byte-memory port.
- Used as an on-die or FPGA-side memory front end and as the synthesizable memory model in core-level benches.
- SCK/CS/SIO are synchronous to the block's clock and are oversampled.

Parameters:
- ADDR_W, 16: memory address width; only the low ADDR_W bits of the 24-bit bus address are used.
- DUMMY_NIBBLES, 2: dummy SCK cycles between the last address nibble and the first read data nibble; range 0..7.

Ports:
- i_resp_gck  in  1  clock; all logic on the rising edge.
- i_resp_rst_n  in  1  reset, asynchronous, active-low.
- i_resp_sck  in  1  SQI serial clock from the initiator.
- i_resp_cs  in  1  chip select, active-low.
- i_resp_sio  in  4  SQI data from the initiator.
- o_resp_sio  out  4  SQI read data to the initiator.
- o_resp_sio_oe  out  1  1 = responder drives SIO.
- o_resp_mem_addr  out  ADDR_W  byte address.
- o_resp_mem_wdata  out  8  write byte.
- o_resp_mem_we  out  1  write strobe, one cycle.
- o_resp_mem_re  out  1  read strobe, one cycle.
- i_resp_mem_rdata  in  8  read byte; valid the cycle after o_resp_mem_re.

Behaviour:
- Reset: all outputs are 0 and state is IDLE. Asserting reset mid-transaction drops o_resp_sio_oe immediately.
- Edge detection: a registered copy sck_q is kept.
  - rise = sck & ~sck_q & ~cs
  - fall = ~sck & sck_q & ~cs
- Timing requirement: SCK high and low phases are each ≥2 gck cycles.
- Nibble order: MSB-first everywhere. SIO is sampled on rise; o_resp_sio is updated on fall.
- States: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
- IDLE -> CMD on the gck cycle where cs is sampled low.
- CMD: 2 rises shift in the command byte.
  - 0x03 -> ADDR(read); 0x02 -> ADDR(write); other values per the optional feature.
- ADDR: 6 rises shift a 24-bit address; the low ADDR_W bits are kept.
  - Read: the final rise pulses re with that address, then moves to DUMMY (or RDATA when DUMMY_NIBBLES=0).
  - Write: moves to WDATA.
- DUMMY: counts DUMMY_NIBBLES rises, then -> RDATA. The captured rdata is held in a byte buffer.
- RDATA:
  - Each fall drives oe=1 and the next nibble: buffer[7:4], then buffer[3:0].
  - On the rise sampling the low nibble: addr increments, re pulses, and the returned byte reloads the buffer before the next fall.
  - The first fall in RDATA is the first fall after entry.
- WDATA:
  - Each rise shifts one nibble.
  - On the second nibble: we=1 for one cycle with the current addr and assembled byte, then addr increments.
- Address wraps modulo 2^ADDR_W.
- Deselect: cs sampled high in any state -> IDLE next cycle with oe=0.
  - A partially received byte is discarded; no strobe is issued.
- Simultaneous cs high and sck rise: cs wins; the nibble is ignored.
- If cs falls while sck is high, no rise is counted until sck has gone low.
- re and we are never asserted in the same cycle.

Optional Feature:
- Macro: IDLI_SQI_RESP_CMD_CHECK_EN.
- Defined: any command other than 0x02/0x03 -> IGNORE. IGNORE issues no strobes, keeps oe=0, and exits only on deselect.
- Undefined: command bit 0 selects the operation (1 = read, 0 = write). There is no IGNORE state.

Test Plan:
- Write 0x02, addr 0x000010, data A,5,3,C -> we at addr 0x0010 with wdata 0xA5, then at 0x0011 with 0x3C. No re.
- Read 0x03, addr 0x000010, 2 dummy nibbles, memory preloaded A5 3C -> SIO nibbles A,5,3,C.
  - re at 0x0010, 0x0011, 0x0012.
  - oe rises on the first fall after the dummy nibbles.
- Write at addr 0x00FFFF with bytes 11, 22 -> we at 0xFFFF, then at 0x0000 (wrap).
- Deselect after 1 write-data nibble -> no we. An immediately following read of 0x0000 still returns correct data.
- Command 0x05:
  - Macro defined: no re/we and oe stays 0 until cs is high.
  - Macro undefined: decoded as a read (bit 0 set) and re pulses after the address phase.
- Async reset asserted during RDATA -> oe=0 and strobes=0 in the same cycle. After release, the next transaction decodes from CMD.
